grade_bank_tracker: RTL and testbench

- Parametrised successor to the single-grade tracker core. Accumulates a grade from debounced step buttons and stores up to DEPTH saved grades.
- Computes the integer average with a sequential divider.
- In display mode it cycles through the saved grades, then the average, on a slow tick.
- Sits between the clock divider (supplies tick) and the seven-segment decoder (consumes gradeOut).

---
 rtl/grade_bank_tracker.sv | 256 +++++++++++++++++++++++++
 tb/tb_grade_bank_tracker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grade_bank_tracker.sv
// grade_bank_tracker: builds a grade from debounced step buttons, banks up
// to DEPTH grades, divides their sum sequentially for the average and then
// cycles the banked grades plus the average on the display.
module grade_bank_tracker #(
  parameter int unsigned GRADE_W   = 8,
  parameter int unsigned GRADE_MAX = 100,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned STEP_A    = 1,
  parameter int unsigned STEP_B    = 5,
  parameter int unsigned STEP_C    = 25,
  parameter int unsigned DWELL     = 4
) (
  input  logic                         CLK,
  input  logic                         resetN,
  input  logic                         tick,
  input  logic                         incA,
  input  logic                         incB,
  input  logic                         incC,
  input  logic                         saveGrade,
  input  logic                         clearCurrent,
  input  logic                         resetGrades,
  input  logic                         displayGrades,
  output logic [GRADE_W-1:0]           gradeOut,
  output logic [$clog2(DEPTH+1)-1:0]   gradeIndex,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [GRADE_W-1:0]           average,
  output logic [1:0]                   mode,
  output logic                         full,
  output logic                         busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = GRADE_W + CNT_W;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DWL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned DIV_W = $clog2(SUM_W + 1);
  localparam int unsigned ADD_W = GRADE_W + 2;
  localparam int unsigned NBTN  = 7;

  // Button bit positions inside the conditioned pulse vector
  localparam int unsigned B_A   = 0;
  localparam int unsigned B_B   = 1;
  localparam int unsigned B_C   = 2;
  localparam int unsigned B_SAV = 3;
  localparam int unsigned B_CLR = 4;
  localparam int unsigned B_RG  = 5;
  localparam int unsigned B_DSP = 6;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_AVG   = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  logic [NBTN-1:0]    btn_raw;
  logic [NBTN-1:0]    sync1_q, sync2_q, prev_q;
  logic [NBTN-1:0]    pulse;

  state_e             state_q, state_d;
  logic [GRADE_W-1:0] cur_q, cur_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GRADE_W-1:0] avg_q, avg_d;
  logic [CNT_W-1:0]   slot_q, slot_d;
  logic [DWL_W-1:0]   dwell_q, dwell_d;
  logic [SUM_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [GRADE_W-1:0] gout_q, gout_d;
  logic [CNT_W-1:0]   gidx_q, gidx_d;
  logic [1:0]         mode_q, mode_d;
  logic               busy_q, busy_d;

  logic [GRADE_W-1:0] mem_q [DEPTH];
  logic               mem_we;

  logic               is_full;
  logic [ADD_W-1:0]   step_sum;
  logic [ADD_W-1:0]   inc_sum;
  logic [GRADE_W-1:0] inc_sat;
  logic [CNT_W:0]     rem_shift;
  logic               rem_ge;
  logic [SUM_W-1:0]   quo_next;

  assign btn_raw = {displayGrades, resetGrades, clearCurrent, saveGrade, incC, incB, incA};
  assign pulse   = sync2_q & ~prev_q;
  assign is_full = (cnt_q == CNT_W'(DEPTH));

  assign gradeOut   = gout_q;
  assign gradeIndex = gidx_q;
  assign count      = cnt_q;
  assign average    = avg_q;
  assign mode       = mode_q;
  assign busy       = busy_q;
  assign full       = is_full;

  // Two-flop synchroniser plus rising-edge history for all buttons
  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Saturating add of every step button pulsed this cycle
  always_comb begin
    step_sum = '0;
    if (pulse[B_A]) step_sum = step_sum + ADD_W'(STEP_A);
    if (pulse[B_B]) step_sum = step_sum + ADD_W'(STEP_B);
    if (pulse[B_C]) step_sum = step_sum + ADD_W'(STEP_C);
    inc_sum = ADD_W'(cur_q) + step_sum;
    inc_sat = (inc_sum > ADD_W'(GRADE_MAX)) ? GRADE_W'(GRADE_MAX) : GRADE_W'(inc_sum);
  end

  // One restoring divide step: shift in next dividend bit, subtract if it fits
  always_comb begin
    rem_shift = {rem_q, quo_q[SUM_W-1]};
    rem_ge    = (rem_shift >= {1'b0, cnt_q});
    quo_next  = {quo_q[SUM_W-2:0], rem_ge};
  end

  // Next-state, datapath updates and registered-output values
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    slot_d  = slot_q;
    dwell_d = dwell_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    mem_we  = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (pulse[B_CLR]) begin
          cur_d = '0;
        end else if (pulse[B_SAV]) begin
          if (!is_full) begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            sum_d  = sum_q + SUM_W'(cur_q);
            cur_d  = '0;
          end
        end else if (|pulse[B_C:B_A]) begin
          cur_d = inc_sat;
        end
        // Use post-save count/sum so a same-cycle save is included
        if (pulse[B_DSP] && (cnt_d != '0)) begin
          state_d = ST_AVG;
          quo_d   = sum_d;
          rem_d   = '0;
          div_d   = '0;
        end
      end
      ST_AVG: begin
        quo_d = quo_next;
        rem_d = rem_ge ? CNT_W'(rem_shift - {1'b0, cnt_q}) : CNT_W'(rem_shift);
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_W'(SUM_W - 1)) begin
          avg_d   = quo_next[GRADE_W-1:0];
          state_d = ST_SHOW;
          slot_d  = '0;
          dwell_d = '0;
        end
      end
      ST_SHOW: begin
        if (pulse[B_DSP]) begin
          state_d = ST_ENTRY;
        end else if (tick) begin
          if (dwell_q == DWL_W'(DWELL - 1)) begin
            dwell_d = '0;
            slot_d  = (slot_q == cnt_q) ? '0 : slot_q + CNT_W'(1);
          end else begin
            dwell_d = dwell_q + DWL_W'(1);
          end
        end
      end
      default: state_d = ST_ENTRY;
    endcase

    // Erasing the bank overrides everything, including a divide in flight
    if (pulse[B_RG]) begin
      state_d = ST_ENTRY;
      cnt_d   = '0;
      sum_d   = '0;
      cur_d   = '0;
      avg_d   = '0;
      slot_d  = '0;
      dwell_d = '0;
      quo_d   = '0;
      rem_d   = '0;
      div_d   = '0;
      mem_we  = 1'b0;
    end

    mode_d = state_d;
    busy_d = (state_d == ST_AVG);
    gidx_d = (state_d == ST_SHOW) ? slot_d : '0;
    case (state_d)
      ST_ENTRY: gout_d = cur_d;
      ST_SHOW:  gout_d = (slot_d < cnt_d) ? mem_q[slot_d[IDX_W-1:0]] : avg_d;
      default:  gout_d = gout_q;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_ENTRY;
      cur_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      slot_q  <= '0;
      dwell_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      gout_q  <= '0;
      gidx_q  <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      slot_q  <= slot_d;
      dwell_q <= dwell_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      gout_q  <= gout_d;
      gidx_q  <= gidx_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
    end
  end

  // Grade bank storage; contents are don't-care after reset
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[cnt_q[IDX_W-1:0]] <= cur_q;
    end
  end

endmodule

// File: tb/tb_grade_bank_tracker.sv
// Directed bench for grade_bank_tracker with hand-computed expectations.
module tb_grade_bank_tracker;

  localparam int unsigned GRADE_W = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SUM_W   = 12;

  localparam logic [6:0] BA  = 7'h01;
  localparam logic [6:0] BB  = 7'h02;
  localparam logic [6:0] BC  = 7'h04;
  localparam logic [6:0] BS  = 7'h08;
  localparam logic [6:0] BCL = 7'h10;
  localparam logic [6:0] BRG = 7'h20;
  localparam logic [6:0] BD  = 7'h40;

  logic CLK = 1'b0;
  logic resetN, tick;
  logic incA, incB, incC, saveGrade, clearCurrent, resetGrades, displayGrades;
  logic [GRADE_W-1:0] gradeOut, average;
  logic [CNT_W-1:0]   gradeIndex, count;
  logic [1:0]         mode;
  logic               full, busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  grade_bank_tracker dut (
    .CLK          (CLK),
    .resetN       (resetN),
    .tick         (tick),
    .incA         (incA),
    .incB         (incB),
    .incC         (incC),
    .saveGrade    (saveGrade),
    .clearCurrent (clearCurrent),
    .resetGrades  (resetGrades),
    .displayGrades(displayGrades),
    .gradeOut     (gradeOut),
    .gradeIndex   (gradeIndex),
    .count        (count),
    .average      (average),
    .mode         (mode),
    .full         (full),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] m);
    incA          = m[0];
    incB          = m[1];
    incC          = m[2];
    saveGrade     = m[3];
    clearCurrent  = m[4];
    resetGrades   = m[5];
    displayGrades = m[6];
  endtask

  // Hold a button combination for 'hold' cycles, then release and let it settle
  task automatic press(input logic [6:0] m, input int hold);
    @(negedge CLK);
    drive(m);
    repeat (hold) @(posedge CLK);
    @(negedge CLK);
    drive('0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_val(input int nc, input int nb, input int na);
    press(BCL, 4);
    for (int i = 0; i < nc; i++) press(BC, 4);
    for (int i = 0; i < nb; i++) press(BB, 4);
    for (int i = 0; i < na; i++) press(BA, 4);
  endtask

  task automatic do_tick();
    @(negedge CLK);
    tick = 1'b1;
    @(negedge CLK);
    tick = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] show_exp [4];
    show_exp[0] = 8'd90;
    show_exp[1] = 8'd85;
    show_exp[2] = 8'd70;
    show_exp[3] = 8'd81;

    resetN = 1'b0;
    tick   = 1'b0;
    drive('0);
    #3;
    chk("rst_gradeOut", gradeOut, 0);
    chk("rst_count", count, 0);
    chk("rst_mode", mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_average", average, 0);
    chk("rst_gradeIndex", gradeIndex, 0);
    @(negedge CLK);
    resetN = 1'b1;

    // Asynchronous reset mid-operation
    press(BC, 4);
    press(BC, 4);
    press(BS, 4);
    chk("pre_rst_count", count, 1);
    press(BC, 4);
    press(BC, 4);
    chk("pre_rst_cur", gradeOut, 50);
    #2 resetN = 1'b0;
    #1;
    chk("async_rst_gradeOut", gradeOut, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_mode", mode, 0);
    @(negedge CLK);
    resetN = 1'b1;

    // Saturation and simultaneous increments
    for (int i = 0; i < 4; i++) press(BC, 4);
    chk("four_incC", gradeOut, 100);
    press(BC, 4);
    chk("sat_hold_100", gradeOut, 100);
    set_val(3, 3, 0);
    chk("cur_90", gradeOut, 90);
    press(BA | BB, 4);
    chk("incA_incB_together", gradeOut, 96);
    press(BC, 4);
    chk("sat_no_wrap", gradeOut, 100);
    press(BCL, 4);
    chk("clear_cur", gradeOut, 0);
    press(BA, 12);
    chk("held_incA_once", gradeOut, 1);

    // Fill the bank with 10..80
    for (int i = 1; i <= 8; i++) begin
      set_val(0, 2 * i, 0);
      press(BS, 4);
      chk("save_count", count, i);
      chk("save_full", full, (i == 8) ? 1 : 0);
    end
    press(BC, 4);
    press(BS, 4);
    chk("ninth_save_count", count, 8);
    chk("ninth_save_cur_kept", gradeOut, 25);
    press(BCL, 4);
    chk("clear_after_full", gradeOut, 0);

    // Erase, then display with an empty bank
    press(BRG, 4);
    chk("erase_count", count, 0);
    chk("erase_full", full, 0);
    press(BD, 4);
    chk("empty_display_mode", mode, 0);

    // Store 90, 85, 70 and run the average
    set_val(3, 3, 0);
    press(BS, 4);
    set_val(3, 2, 0);
    press(BS, 4);
    set_val(2, 4, 0);
    press(BS, 4);
    chk("three_saved", count, 3);
    press(BB, 4);
    chk("prior_cur", gradeOut, 5);

    @(negedge CLK);
    drive(BD);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("avg_mode", mode, 1);
    chk("avg_gradeOut_hold", gradeOut, 5);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk("avg_busy_cycles", n, SUM_W);
    drive('0);
    chk("avg_value", average, 81);
    chk("show_mode", mode, 2);
    repeat (4) @(negedge CLK);

    // Display cycling through bank and average
    for (int k = 0; k < 4; k++) begin
      chk("show_value", gradeOut, show_exp[k]);
      chk("show_index", gradeIndex, k);
      repeat (3) do_tick();
      chk("show_dwell_value", gradeOut, show_exp[k]);
      do_tick();
    end
    chk("show_wrap_value", gradeOut, 90);
    chk("show_wrap_index", gradeIndex, 0);

    // Leave display mode with current intact
    press(BD, 4);
    chk("exit_mode", mode, 0);
    chk("exit_cur", gradeOut, 5);
    chk("exit_index", gradeIndex, 0);
    chk("exit_count", count, 3);

    // Erase while the divider is running
    @(negedge CLK);
    drive(BD);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("avg2_busy", busy, 1);
    drive(BRG);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("abort_mode", mode, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", count, 0);
    chk("abort_average", average, 0);
    chk("abort_gradeOut", gradeOut, 0);
    drive(BRG | BA);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("held_erase_once", gradeOut, 1);
    repeat (16) @(negedge CLK);
    chk("abort_stays_entry", mode, 0);
    chk("abort_cur_kept", gradeOut, 1);
    drive('0);
    repeat (4) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
